// File: rtl/motor_pwm_driver_pkg.sv
// Shared types and constants for the motor PWM driver and its upstream servo controller.
//   PWM_CNT_W      : width of period/duty/PWM counter, shared with servo_controller_unit
//   drive_state_t  : H-bridge drive FSM state, also exported on drive_state
//   drive_cmd_t    : direction/brake/power command bits held in the shadow register
package motor_pkg;

    localparam int unsigned PWM_CNT_W = 8;

    typedef enum logic [1:0] {
        DS_OFF      = 2'd0,
        DS_DRIVE    = 2'd1,
        DS_BRAKE    = 2'd2,
        DS_DEADTIME = 2'd3
    } drive_state_t;

    typedef struct packed {
        logic cw;
        logic brk;
        logic pwr;
    } drive_cmd_t;

endpackage

// File: rtl/motor_pwm_driver_if.sv
// Command/status bundle between the servo controller and the motor PWM driver.
//   pwm_period, pwm_duty, clockwise, pwm_brake, pwm_power : commands (master -> slave)
//   motor_a, motor_b, pwm_out, period_strobe, drive_state  : status   (slave -> master)
interface motor_pwm_driver_if #(
    parameter int unsigned CNT_W = motor_pkg::PWM_CNT_W
);
    import motor_pkg::*;

    logic [CNT_W-1:0] pwm_period;
    logic [CNT_W-1:0] pwm_duty;
    logic             clockwise;
    logic             pwm_brake;
    logic             pwm_power;
    logic             motor_a;
    logic             motor_b;
    logic             pwm_out;
    logic             period_strobe;
    drive_state_t     drive_state;

    modport master (
        output pwm_period, pwm_duty, clockwise, pwm_brake, pwm_power,
        input  motor_a, motor_b, pwm_out, period_strobe, drive_state
    );

    modport slave (
        input  pwm_period, pwm_duty, clockwise, pwm_brake, pwm_power,
        output motor_a, motor_b, pwm_out, period_strobe, drive_state
    );

endinterface

// File: rtl/motor_pwm_driver_timebase.sv
// PWM timebase: prescaler, period counter, shadowed period and period strobe.
//   clk, n_reset   : clock, synchronous active-low reset
//   pwm_period     : requested period (ticks minus 1), sampled at each wrap
//   cnt_nxt_c      : counter value that takes effect at the coming edge (combinational)
//   wrap_c         : coming edge ends the period and reloads shadows (combinational)
//   period_strobe  : registered 1-clk pulse following each wrap
module pwm_timebase
    import motor_pkg::*;
#(
    parameter int unsigned PRESCALE_DIV = 50,
    parameter int unsigned CNT_W        = PWM_CNT_W
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [CNT_W-1:0] pwm_period,
    output logic [CNT_W-1:0] cnt_nxt_c,
    output logic             wrap_c,
    output logic             period_strobe
);

    localparam int unsigned PRE_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);

    logic [PRE_W-1:0] pre_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] per_sh;
    logic             tick_c;

    assign tick_c = (pre_q == PRE_LAST);
    // A zero period wraps on every tick, holding cnt at 0.
    assign wrap_c = tick_c && (cnt_q == per_sh);

    // Next counter value
    always_comb begin
        cnt_nxt_c = cnt_q;
        if (tick_c) begin
            cnt_nxt_c = wrap_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Prescaler, counter, period shadow and strobe
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            pre_q         <= '0;
            cnt_q         <= '0;
            per_sh        <= '0;
            period_strobe <= 1'b0;
        end else begin
            pre_q         <= tick_c ? '0 : pre_q + PRE_W'(1);
            cnt_q         <= cnt_nxt_c;
            period_strobe <= wrap_c;
            if (wrap_c) begin
                per_sh <= pwm_period;
            end
        end
    end

endmodule

// File: rtl/motor_pwm_driver.sv
// H-bridge gate driver: double-buffered PWM with dead-time between drive modes.
//   clk, n_reset : clock, synchronous active-low reset
//   bus (slave)  : pwm_period/pwm_duty/clockwise/pwm_brake/pwm_power in;
//                  motor_a/motor_b gates, pwm_out monitor, period_strobe, drive_state out
// Shadows reload only at period wrap; pwm_power low forces DS_OFF on the next edge.
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int unsigned PRESCALE_DIV    = 50,
    parameter int unsigned DEADTIME_CYCLES = 16,
    parameter int unsigned CNT_W           = PWM_CNT_W
) (
    input  logic         clk,
    input  logic         n_reset,
    motor_pwm_driver_if.slave bus
);

    localparam int unsigned DT_W = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;
    localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME_CYCLES - 1);

    logic [CNT_W-1:0] cnt_nxt_c;
    logic             wrap_c;
    logic             strobe_q;

    drive_state_t     state_q, state_d;
    logic [DT_W-1:0]  dt_q, dt_d;
    logic [CNT_W-1:0] duty_sh, duty_d;
    drive_cmd_t       cmd_sh, cmd_d;
    logic             pwm_d, a_d, b_d;
    logic             pwm_q, a_q, b_q;

    pwm_timebase #(
        .PRESCALE_DIV (PRESCALE_DIV),
        .CNT_W        (CNT_W)
    ) u_timebase (
        .clk           (clk),
        .n_reset       (n_reset),
        .pwm_period    (bus.pwm_period),
        .cnt_nxt_c     (cnt_nxt_c),
        .wrap_c        (wrap_c),
        .period_strobe (strobe_q)
    );

    // State, dead-time counter, shadows and registered outputs
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= DS_OFF;
            dt_q    <= '0;
            duty_sh <= '0;
            cmd_sh  <= '0;
            pwm_q   <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            dt_q    <= dt_d;
            duty_sh <= duty_d;
            cmd_sh  <= cmd_d;
            pwm_q   <= pwm_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Shadow reload, next state and next gate values
    always_comb begin
        duty_d  = duty_sh;
        cmd_d   = cmd_sh;
        state_d = state_q;
        dt_d    = dt_q;
        a_d     = 1'b0;
        b_d     = 1'b0;

        if (wrap_c) begin
            duty_d    = bus.pwm_duty;
            cmd_d.cw  = bus.clockwise;
            cmd_d.brk = bus.pwm_brake;
            cmd_d.pwr = bus.pwm_power;
        end

        case (state_q)
            DS_OFF: begin
                // Legs already low, so no dead-time is needed on the way out.
                if (wrap_c && cmd_d.pwr) begin
                    state_d = cmd_d.brk ? DS_BRAKE : DS_DRIVE;
                end
            end
            DS_DRIVE: begin
                if (wrap_c && ((cmd_d.cw != cmd_sh.cw) || cmd_d.brk)) begin
                    state_d = DS_DEADTIME;
                    dt_d    = DT_LOAD;
                end
            end
            DS_BRAKE: begin
                if (wrap_c && !cmd_d.brk) begin
                    state_d = DS_DEADTIME;
                    dt_d    = DT_LOAD;
                end
            end
            DS_DEADTIME: begin
                // Strobes here refresh shadows but never restart the count.
                if (dt_q == '0) begin
                    if (!cmd_sh.pwr) begin
                        state_d = DS_OFF;
                    end else if (cmd_sh.brk) begin
                        state_d = DS_BRAKE;
                    end else begin
                        state_d = DS_DRIVE;
                    end
                end else begin
                    dt_d = dt_q - DT_W'(1);
                end
            end
            default: state_d = DS_OFF;
        endcase

        // Raw power input overrides everything, including a coincident strobe.
        if (!bus.pwm_power) begin
            state_d   = DS_OFF;
            cmd_d.pwr = 1'b0;
        end

        pwm_d = (cnt_nxt_c < duty_d);

        case (state_d)
            DS_DRIVE: begin
                a_d = cmd_d.cw & pwm_d;
                b_d = ~cmd_d.cw & pwm_d;
            end
            DS_BRAKE: begin
                a_d = 1'b1;
                b_d = 1'b1;
            end
            default: begin
                a_d = 1'b0;
                b_d = 1'b0;
            end
        endcase
    end

    assign bus.motor_a       = a_q;
    assign bus.motor_b       = b_q;
    assign bus.pwm_out       = pwm_q;
    assign bus.period_strobe = strobe_q;
    assign bus.drive_state   = state_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: two instances (prescale 1 and 3) share one command
// stream and are compared every clock against a behavioural model, plus directed
// checks of duty, direction change, brake and power override.
module tb_motor_pwm_driver;
    import motor_pkg::*;

    localparam int unsigned DT_N = 4;

    typedef struct {
        int pre;
        int cnt;
        int per;
        int duty;
        bit cw;
        bit brk;
        bit pwr;
        int st;
        int dt;
        bit a;
        bit b;
        bit pwm;
        bit strb;
    } mdl_t;

    logic clk = 1'b0;
    logic n_reset;
    logic [PWM_CNT_W-1:0] per_i, duty_i;
    logic cw_i, brk_i, pwr_i;

    int n_cmp = 0;
    int n_err = 0;
    mdl_t m1, m3;
    logic pa1, pb1, pa3, pb3;

    always #5 clk = ~clk;

    motor_pwm_driver_if #(.CNT_W(PWM_CNT_W)) bus1 ();
    motor_pwm_driver_if #(.CNT_W(PWM_CNT_W)) bus3 ();

    assign bus1.pwm_period = per_i;
    assign bus1.pwm_duty   = duty_i;
    assign bus1.clockwise  = cw_i;
    assign bus1.pwm_brake  = brk_i;
    assign bus1.pwm_power  = pwr_i;
    assign bus3.pwm_period = per_i;
    assign bus3.pwm_duty   = duty_i;
    assign bus3.clockwise  = cw_i;
    assign bus3.pwm_brake  = brk_i;
    assign bus3.pwm_power  = pwr_i;

    motor_pwm_driver #(.PRESCALE_DIV(1), .DEADTIME_CYCLES(DT_N), .CNT_W(PWM_CNT_W)) dut1 (
        .clk(clk), .n_reset(n_reset), .bus(bus1)
    );
    motor_pwm_driver #(.PRESCALE_DIV(3), .DEADTIME_CYCLES(DT_N), .CNT_W(PWM_CNT_W)) dut3 (
        .clk(clk), .n_reset(n_reset), .bus(bus3)
    );

    // One clock of the driver, described in terms of period position and drive mode.
    function automatic mdl_t mstep(input mdl_t m, input int div);
        mdl_t n = m;
        bit tick, wrap;
        if (!n_reset) begin
            n = '{default: 0};
            return n;
        end
        tick   = (m.pre == div - 1);
        n.pre  = tick ? 0 : m.pre + 1;
        wrap   = tick && (m.cnt == m.per);
        if (tick) n.cnt = wrap ? 0 : m.cnt + 1;
        n.strb = wrap;
        if (wrap) begin
            n.per = int'(per_i); n.duty = int'(duty_i);
            n.cw = cw_i; n.brk = brk_i; n.pwr = pwr_i;
        end
        if (!pwr_i) begin
            n.st  = int'(DS_OFF);
            n.pwr = 1'b0;
        end else if (m.st == int'(DS_OFF)) begin
            if (wrap && n.pwr) n.st = n.brk ? int'(DS_BRAKE) : int'(DS_DRIVE);
        end else if (m.st == int'(DS_DRIVE)) begin
            if (wrap && (n.cw != m.cw || n.brk)) begin n.st = int'(DS_DEADTIME); n.dt = DT_N - 1; end
        end else if (m.st == int'(DS_BRAKE)) begin
            if (wrap && !n.brk) begin n.st = int'(DS_DEADTIME); n.dt = DT_N - 1; end
        end else begin
            if (m.dt == 0) n.st = !m.pwr ? int'(DS_OFF) : (m.brk ? int'(DS_BRAKE) : int'(DS_DRIVE));
            else n.dt = m.dt - 1;
        end
        n.pwm = (n.cnt < n.duty);
        n.a = (n.st == int'(DS_BRAKE)) || (n.st == int'(DS_DRIVE) && n.cw && n.pwm);
        n.b = (n.st == int'(DS_BRAKE)) || (n.st == int'(DS_DRIVE) && !n.cw && n.pwm);
        return n;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string tag, input logic a, input logic b, input logic pwm,
                             input logic strb, input drive_state_t st, input logic pa,
                             input logic pb, input mdl_t m);
        chk({tag, ".motor_a"}, int'(a), int'(m.a));
        chk({tag, ".motor_b"}, int'(b), int'(m.b));
        chk({tag, ".pwm_out"}, int'(pwm), int'(m.pwm));
        chk({tag, ".strobe"}, int'(strb), int'(m.strb));
        chk({tag, ".state"}, int'(st), m.st);
        // Legs must never swap (one rising while the other falls) in one clk.
        chk({tag, ".swap"}, int'((a != pa) && (b != pb) && (a != b)), 0);
        chk({tag, ".both_high"}, int'(a && b && (st != DS_BRAKE)), 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        m1 = mstep(m1, 1);
        m3 = mstep(m3, 3);
        #1;
        check_dut("d1", bus1.motor_a, bus1.motor_b, bus1.pwm_out, bus1.period_strobe,
                  bus1.drive_state, pa1, pb1, m1);
        check_dut("d3", bus3.motor_a, bus3.motor_b, bus3.pwm_out, bus3.period_strobe,
                  bus3.drive_state, pa3, pb3, m3);
        pa1 = bus1.motor_a; pb1 = bus1.motor_b;
        pa3 = bus3.motor_a; pb3 = bus3.motor_b;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_strobe();
        int k = 0;
        while (!bus1.period_strobe && k < 400) begin
            cyc();
            k++;
        end
        chk("strobe_seen", int'(bus1.period_strobe), 1);
    endtask

    // Counts dut1 activity over n cycles, starting with the current one.
    task automatic run_count(input int n, output int na, output int nb, output int np,
                             output int ns, output int nd);
        na = 0; nb = 0; np = 0; ns = 0; nd = 0;
        for (int i = 0; i < n; i++) begin
            na += int'(bus1.motor_a);
            nb += int'(bus1.motor_b);
            np += int'(bus1.pwm_out);
            ns += int'(bus1.period_strobe);
            nd += int'(bus1.drive_state == DS_DEADTIME);
            cyc();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nb, np, ns, nd;
        m1 = '{default: 0};
        m3 = '{default: 0};
        pa1 = 1'b0; pb1 = 1'b0; pa3 = 1'b0; pb3 = 1'b0;

        // Reset with active inputs
        n_reset = 1'b0;
        per_i = 8'd9; duty_i = 8'd3; cw_i = 1'b1; brk_i = 1'b0; pwr_i = 1'b1;
        cycles(3);
        chk("rst.motor_a", int'(bus1.motor_a), 0);
        chk("rst.motor_b", int'(bus1.motor_b), 0);
        chk("rst.pwm_out", int'(bus1.pwm_out), 0);
        chk("rst.strobe", int'(bus1.period_strobe), 0);
        chk("rst.state", int'(bus1.drive_state), int'(DS_OFF));
        n_reset = 1'b1;

        // Basic drive: period 10, duty 3, clockwise
        cyc();
        chk("drv.state", int'(bus1.drive_state), int'(DS_DRIVE));
        cyc();
        wait_strobe();
        run_count(10, na, nb, np, ns, nd);
        chk("drv.a_high", na, 3);
        chk("drv.b_high", nb, 0);
        chk("drv.strobes", ns, 1);

        // Duty extremes and zero period
        duty_i = 8'd0;
        cyc(); wait_strobe();
        run_count(10, na, nb, np, ns, nd);
        chk("duty0.pwm", np, 0);
        duty_i = 8'd200;
        cyc(); wait_strobe();
        run_count(10, na, nb, np, ns, nd);
        chk("duty200.pwm", np, 10);
        per_i = 8'd0; duty_i = 8'd0;
        cyc(); wait_strobe();
        run_count(10, na, nb, np, ns, nd);
        chk("per0.pwm", np, 0);
        chk("per0.strobes", ns, 10);
        per_i = 8'd9; duty_i = 8'd3;
        cyc();

        // Direction flip mid-period
        cyc(); wait_strobe();
        cycles(4);
        cw_i = 1'b0;
        wait_strobe();
        chk("dir.state_dt", int'(bus1.drive_state), int'(DS_DEADTIME));
        run_count(4, na, nb, np, ns, nd);
        chk("dir.dt_len", nd, 4);
        chk("dir.dt_legs", na + nb, 0);
        chk("dir.state_drv", int'(bus1.drive_state), int'(DS_DRIVE));
        wait_strobe();
        run_count(10, na, nb, np, ns, nd);
        chk("dir.b_high", nb, 3);
        chk("dir.a_high", na, 0);

        // Brake and release
        brk_i = 1'b1;
        cyc(); wait_strobe();
        chk("brk.state_dt", int'(bus1.drive_state), int'(DS_DEADTIME));
        run_count(4, na, nb, np, ns, nd);
        chk("brk.dt_len", nd, 4);
        chk("brk.dt_legs", na + nb, 0);
        chk("brk.state", int'(bus1.drive_state), int'(DS_BRAKE));
        chk("brk.legs", int'({bus1.motor_a, bus1.motor_b}), 3);
        brk_i = 1'b0;
        cyc(); wait_strobe();
        chk("rel.state_dt", int'(bus1.drive_state), int'(DS_DEADTIME));
        run_count(4, na, nb, np, ns, nd);
        chk("rel.dt_len", nd, 4);
        chk("rel.state", int'(bus1.drive_state), int'(DS_DRIVE));

        // Power override mid-period, then return through a strobe
        cycles(2);
        pwr_i = 1'b0;
        cyc();
        chk("pwr.state", int'(bus1.drive_state), int'(DS_OFF));
        chk("pwr.legs", int'({bus1.motor_a, bus1.motor_b}), 0);
        cyc(); wait_strobe();
        chk("pwr.strobe_off", int'(bus1.drive_state), int'(DS_OFF));
        pwr_i = 1'b1;
        cyc();
        chk("pwr.wait", int'(bus1.drive_state), int'(DS_OFF));
        wait_strobe();
        chk("pwr.resume", int'(bus1.drive_state), int'(DS_DRIVE));

        // Power override on a strobe clk
        cycles(9);
        pwr_i = 1'b0;
        cyc();
        chk("pwrs.strobe", int'(bus1.period_strobe), 1);
        chk("pwrs.state", int'(bus1.drive_state), int'(DS_OFF));
        chk("pwrs.legs", int'({bus1.motor_a, bus1.motor_b}), 0);
        pwr_i = 1'b1;
        cyc(); wait_strobe();
        chk("pwrs.resume", int'(bus1.drive_state), int'(DS_DRIVE));

        // Randomized commands, occasional power drop and reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) per_i = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 29) == 0)
                duty_i = ($urandom_range(0, 9) == 0) ? 8'd200 : 8'($urandom_range(0, 14));
            if ($urandom_range(0, 59) == 0) cw_i = ~cw_i;
            if ($urandom_range(0, 79) == 0) brk_i = ~brk_i;
            if (pwr_i) begin
                if ($urandom_range(0, 149) == 0) pwr_i = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                pwr_i = 1'b1;
            end
            n_reset = ($urandom_range(0, 499) != 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
